coin_ledger: RTL and testbench

- Holds the live 48-bit coin memory for the two-player game, directly downstream of the starting-memory builder.
- Loads the builder's 48-bit starting_memory on a load pulse.
- Serves transfer requests over a valid/ready handshake: checks the sender's private key, checks the balances, then commits or rejects the transfer.
- Exposes the current memory and a one-cycle result response.

---
 rtl/coin_ledger.sv | 135 +++++++++++++
 tb/tb_coin_ledger.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_ledger.sv
// Live two-player coin ledger: loads a starting memory, then serves key-checked transfers.
// Optional COIN_LEDGER_STATS_EN adds ok_count/fail_count response counters.
module coin_ledger #(
    parameter logic [7:0] MAX_BALANCE = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [47:0] starting_memory,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        tx_from,
    input  logic [7:0]  tx_key,
    input  logic [7:0]  tx_amount,
    output logic        resp_valid,
    output logic [1:0]  resp_code,
    output logic [47:0] memory_out,
    output logic        initialized
`ifdef COIN_LEDGER_STATS_EN
    ,
    output logic [7:0]  ok_count,
    output logic [7:0]  fail_count
`endif
);

    typedef enum logic [2:0] {StUninit, StIdle, StCheck, StCommit, StResp} state_e;

    state_e      state_q;
    logic        from_q;
    logic [7:0]  key_q;
    logic [7:0]  amount_q;
    logic [1:0]  code_q;

    logic [7:0]  sender_key;
    logic [7:0]  sender_money;
    logic [7:0]  recv_money;
    logic [8:0]  recv_sum;
    logic [1:0]  check_code;
    logic [47:0] commit_mem;

    assign tx_ready = (state_q == StIdle) && !load;

    // Byte layout: [47:40] p1 key, [31:24] p1 money, [23:16] p2 key, [7:0] p2 money.
    always_comb begin
        sender_key   = from_q ? memory_out[23:16] : memory_out[47:40];
        sender_money = from_q ? memory_out[7:0]   : memory_out[31:24];
        recv_money   = from_q ? memory_out[31:24] : memory_out[7:0];
        recv_sum     = {1'b0, recv_money} + {1'b0, amount_q};
        if (key_q != sender_key) begin
            check_code = 2'd1;
        end else if (amount_q > sender_money) begin
            check_code = 2'd2;
        end else if (recv_sum > {1'b0, MAX_BALANCE}) begin
            check_code = 2'd3;
        end else begin
            check_code = 2'd0;
        end
    end

    always_comb begin
        commit_mem = memory_out;
        if (from_q) begin
            commit_mem[7:0]   = memory_out[7:0] - amount_q;
            commit_mem[31:24] = memory_out[31:24] + amount_q;
        end else begin
            commit_mem[31:24] = memory_out[31:24] - amount_q;
            commit_mem[7:0]   = memory_out[7:0] + amount_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StUninit;
            from_q      <= 1'b0;
            key_q       <= 8'd0;
            amount_q    <= 8'd0;
            code_q      <= 2'd0;
            resp_valid  <= 1'b0;
            resp_code   <= 2'd0;
            memory_out  <= 48'd0;
            initialized <= 1'b0;
`ifdef COIN_LEDGER_STATS_EN
            ok_count    <= 8'd0;
            fail_count  <= 8'd0;
`endif
        end else if (load) begin
            // Load wins over everything and silently drops any in-flight request.
            state_q     <= StIdle;
            memory_out  <= starting_memory;
            initialized <= 1'b1;
            resp_valid  <= 1'b0;
`ifdef COIN_LEDGER_STATS_EN
            ok_count    <= 8'd0;
            fail_count  <= 8'd0;
`endif
        end else begin
            resp_valid <= 1'b0;
            unique case (state_q)
                StUninit: state_q <= StUninit;
                StIdle: begin
                    if (tx_valid) begin
                        from_q   <= tx_from;
                        key_q    <= tx_key;
                        amount_q <= tx_amount;
                        state_q  <= StCheck;
                    end
                end
                StCheck: begin
                    code_q  <= check_code;
                    state_q <= StCommit;
                end
                StCommit: begin
                    if (code_q == 2'd0) begin
                        memory_out <= commit_mem;
                    end
                    resp_code  <= code_q;
                    resp_valid <= 1'b1;
                    state_q    <= StResp;
                end
                StResp: begin
                    state_q <= StIdle;
`ifdef COIN_LEDGER_STATS_EN
                    if (resp_code == 2'd0) begin
                        ok_count <= ok_count + 8'd1;
                    end else begin
                        fail_count <= fail_count + 8'd1;
                    end
`endif
                end
                default: state_q <= StUninit;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_ledger.sv
// Scoreboard bench for coin_ledger: directed transfers, expectations queued, monitor compares.
module tb_coin_ledger;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [47:0] starting_memory;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_from;
    logic [7:0]  tx_key;
    logic [7:0]  tx_amount;
    logic        resp_valid;
    logic [1:0]  resp_code;
    logic [47:0] memory_out;
    logic        initialized;
`ifdef COIN_LEDGER_STATS_EN
    logic [7:0]  ok_count;
    logic [7:0]  fail_count;
`endif

    coin_ledger #(.MAX_BALANCE(8'h40)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .starting_memory(starting_memory),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_from(tx_from),
        .tx_key(tx_key),
        .tx_amount(tx_amount),
        .resp_valid(resp_valid),
        .resp_code(resp_code),
        .memory_out(memory_out),
        .initialized(initialized)
`ifdef COIN_LEDGER_STATS_EN
        ,
        .ok_count(ok_count),
        .fail_count(fail_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  code;
        logic [47:0] mem;
        int          hs;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int compared = 0;
    int mismatched = 0;
    int exp_ok = 0;
    int exp_fail = 0;

    localparam logic [47:0] L1 = 48'h75_A0_32_1B_B0_32;
    localparam logic [47:0] L2 = 48'h75_A0_3C_1B_B0_3C;
    localparam logic [47:0] L3 = 48'h75_A0_10_1B_B0_00;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 48'd1, 48'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_code"}, 48'(resp_code), 48'(mon_e.code));
                check({mon_e.name, "_mem"}, memory_out, mon_e.mem);
                check({mon_e.name, "_latency"}, 48'(cyc - mon_e.hs), 48'd2);
            end
        end
    end

    task automatic do_tx(input string name, input logic from, input logic [7:0] key,
                         input logic [7:0] amt, input logic [1:0] code, input logic [47:0] mem);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            check({name, "_ready_timeout"}, 48'd0, 48'd1);
            return;
        end
        tx_valid  = 1'b1;
        tx_from   = from;
        tx_key    = key;
        tx_amount = amt;
        @(posedge clk);
        #1;
        sb.push_back('{code, mem, cyc, name});
        if (code == 2'd0) exp_ok++;
        else exp_fail++;
        tx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 48'(sb.size()), 48'd0);
    endtask

    task automatic do_load(input string name, input logic [47:0] v);
        @(negedge clk);
        load = 1'b1;
        starting_memory = v;
        #1;
        check({name, "_ready_during_load"}, 48'(tx_ready), 48'd0);
        @(posedge clk);
        #1;
        load = 1'b0;
        exp_ok = 0;
        exp_fail = 0;
        @(negedge clk);
        check({name, "_mem"}, memory_out, v);
        check({name, "_init"}, 48'(initialized), 48'd1);
        check({name, "_ready"}, 48'(tx_ready), 48'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        load = 1'b0;
        starting_memory = 48'd0;
        tx_valid = 1'b0;
        tx_from = 1'b0;
        tx_key = 8'd0;
        tx_amount = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_mem", memory_out, 48'd0);
        check("reset_init", 48'(initialized), 48'd0);
        check("reset_ready", 48'(tx_ready), 48'd0);
        check("reset_resp", {45'd0, resp_valid, resp_code}, 48'd0);
        reset = 1'b0;

        // Requests before any load are ignored.
        tx_valid = 1'b1;
        tx_key = 8'h75;
        tx_amount = 8'h01;
        repeat (4) begin
            @(negedge clk);
            check("uninit_ready", 48'(tx_ready), 48'd0);
        end
        tx_valid = 1'b0;

        do_load("load1", L1);
        do_tx("t1_ok", 1'b0, 8'h75, 8'h0A, 2'd0, 48'h75_A0_28_1B_B0_3C);
        do_tx("t2_badkey", 1'b1, 8'h75, 8'h05, 2'd1, 48'h75_A0_28_1B_B0_3C);
        do_tx("t3_funds", 1'b1, 8'h1B, 8'h3D, 2'd2, 48'h75_A0_28_1B_B0_3C);
        do_tx("t4_zero", 1'b0, 8'h75, 8'h00, 2'd0, 48'h75_A0_28_1B_B0_3C);
        do_tx("t4b_zero_badkey", 1'b0, 8'h00, 8'h00, 2'd1, 48'h75_A0_28_1B_B0_3C);
        drain("set1");
        @(negedge clk);
        check("resp_code_hold", 48'(resp_code), 48'd1);

        do_load("load2", L2);
        do_tx("t5_over", 1'b1, 8'h1B, 8'h05, 2'd3, L2);
        do_tx("t6_tomax", 1'b1, 8'h1B, 8'h04, 2'd0, 48'h75_A0_40_1B_B0_38);
        drain("set2");

        do_load("load3", L3);
        do_tx("t7_exact", 1'b0, 8'h75, 8'h10, 2'd0, 48'h75_A0_00_1B_B0_10);
        do_tx("t8_keyfirst", 1'b0, 8'h11, 8'hFF, 2'd1, 48'h75_A0_00_1B_B0_10);
        do_tx("t9_empty", 1'b0, 8'h75, 8'h01, 2'd2, 48'h75_A0_00_1B_B0_10);
        drain("set3");

        do_load("load4", L1);
        do_tx("s1_ok", 1'b0, 8'h75, 8'h0A, 2'd0, 48'h75_A0_28_1B_B0_3C);
        do_tx("s2_ok", 1'b1, 8'h1B, 8'h04, 2'd0, 48'h75_A0_2C_1B_B0_38);
        do_tx("s3_fail", 1'b1, 8'h00, 8'h01, 2'd1, 48'h75_A0_2C_1B_B0_38);
        drain("set4");
        @(negedge clk);
`ifdef COIN_LEDGER_STATS_EN
        check("stats_ok", 48'(ok_count), 48'(exp_ok));
        check("stats_fail", 48'(fail_count), 48'(exp_fail));
`endif

        // Abort: handshake, then load during CHECK; no response may follow.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_from = 1'b0;
        tx_key = 8'h75;
        tx_amount = 8'h0A;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        load = 1'b1;
        starting_memory = L1;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        check("abort_ready", 48'(tx_ready), 48'd1);
        repeat (5) @(negedge clk);
        check("abort_mem", memory_out, L1);
`ifdef COIN_LEDGER_STATS_EN
        check("stats_ok_cleared", 48'(ok_count), 48'd0);
        check("stats_fail_cleared", 48'(fail_count), 48'd0);
`endif
        check("final_queue", 48'(sb.size()), 48'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
